irq_ctrl: RTL
=============

# irq_ctrl

Memory-mapped interrupt controller directly downstream of the GPIO/counter-timer peripheral. It consumes that block's `top_interrupt`, `cmpr0_interrupt` and `cmpr1_interrupt` outputs plus other sources on `irq_in`, and latches rising edges into pending bits. It masks and prioritises the pending sources and presents one vectored request to the CPU over a req/ack handshake. The CPU configures and services it through the same 8-bit `din`/`address`/`w_en`/`r_en`/`dout` bus style as the other I/O blocks.

## Interface
- `N_IRQ`, 8: number of sources, 1..8; bit 0 is highest priority.
- `VECTOR_BASE`, 8'h10: vector emitted for source 0.
- `VECTOR_STRIDE`, 4: vector spacing between consecutive sources.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `irq_in`  in  N_IRQ  interrupt sources, level inputs; rising edge = event.
- `din`  in  8  write data.
- `address`  in  8  register offset within this block's window.
- `w_en`  in  1  write strobe, one cycle per write.
- `r_en`  in  1  read strobe.
- `dout`  out  8  registered read data.
- `irq_req`  out  1  interrupt request to CPU.
- `irq_vector`  out  8  vector of the request; stable while `irq_req`=1.
- `irq_ack`  in  1  CPU accepts the request.

## Operation
Registers (unused bits read 0):
- 0x00 ENABLE, R/W: per-source mask.
- 0x01 PENDING: read returns pending bits; write-1-to-clear.
- 0x02 CTRL, R/W: bit0 = global enable (GIE); bit1 = in-service flag, read-only.
- 0x03 EOI, W: any write ends service.
- 0x04 VECTOR, R: vector of the highest-priority enabled pending source, or 8'h00 if none.

- Edge detect: `pending[i]` sets when `irq_in[i]`=1 and its previous sample was 0. Pending latches regardless of ENABLE and GIE.
- Candidate: the lowest index with `pending & ENABLE` set. Vector = `VECTOR_BASE + i*VECTOR_STRIDE`, computed at 8 bits; wrap-around is permitted.
- FSM:
  - IDLE -> REQUEST when GIE=1 and a candidate exists; latch candidate index and vector.
  - REQUEST: `irq_req`=1.
    - On `irq_ack` -> SERVICE; clear the latched pending bit.
    - If GIE is cleared -> IDLE; the pending bit is retained.
  - SERVICE: `irq_req`=0, in-service flag=1. A write to EOI -> IDLE. No nesting: new events only pend.
- Latched vector does not change in REQUEST even if a higher-priority source arrives; that source is taken on the next IDLE pass.
- Simultaneous events:
  - Edge and W1C on the same bit in one cycle: set wins.
  - Edge on the acked source in the ack cycle: set wins, so the source re-pends.
- An ENABLE change during REQUEST does not withdraw the request.
- Reads: `dout` is updated the cycle after `r_en` and holds its value otherwise. Reading an unmapped offset returns 8'h00.

## Timing
- Reset values: `irq_req`=0, `irq_vector`=8'h00, `dout`=8'h00, ENABLE/PENDING/CTRL=0, FSM=IDLE, edge history=0.
  - A source held high through reset deasserting produces one event.
- Latency: `irq_in` is sampled high at edge N, so `pending` is set after N. `irq_req` is 1 after edge N+1 when GIE and ENABLE are already set.
- `irq_ack` is sampled only while `irq_req`=1. `irq_req` falls on the edge that samples ack; ack outside REQUEST is ignored.
- A reset mid-handshake returns immediately to reset values; the CPU must treat the request as dropped.
- Register writes take effect on the edge where `w_en`=1.

## Configuration
- `IRQ_CTRL_SYNC_EN` defined: each `irq_in` passes through a two-flop synchroniser (reset 0) before edge detection, for asynchronous pad sources. This adds 2 cycles to the latency above.
- Undefined: `irq_in` feeds edge detection directly. Sources must be synchronous to `clk`.

## Structure
- Package `irq_ctrl_pkg`: register offset constants, FSM state typedef (IDLE/REQUEST/SERVICE), CTRL bit positions.
- Sub-module `irq_prio_enc`: combinational N_IRQ-bit lowest-index priority encoder (valid + index). The top level instantiates it and computes the vector.

## Test plan
- ENABLE=8'h01, GIE=1; pulse `irq_in[0]` -> `irq_req`=1 two cycles later with vector 8'h10; ack -> PENDING bit0 clears and in-service=1; EOI -> IDLE.
- Pulse sources 2 and 5 in the same cycle, ENABLE=8'hFF -> first vector 8'h18; after ack and EOI, second request with vector 8'h24.
- ENABLE=0, pulse source 3 -> PENDING=8'h08 and no request; then ENABLE=8'h08 -> request with vector 8'h1C.
- In the same cycle, write PENDING=8'h02 and rising edge on `irq_in[1]` -> PENDING bit1 stays 1.
- Raise source 0 during SERVICE of source 4 -> no `irq_req` until EOI; the request follows EOI.
- Assert `rst_n`=0 during REQUEST -> `irq_req`, `irq_vector` and all registers are 0 immediately. With `IRQ_CTRL_SYNC_EN`, latency is 4 cycles.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map, CTRL bit positions and FSM state type for irq_ctrl.
package irq_ctrl_pkg;

  localparam logic [7:0] ADDR_ENABLE  = 8'h00;
  localparam logic [7:0] ADDR_PENDING = 8'h01;
  localparam logic [7:0] ADDR_CTRL    = 8'h02;
  localparam logic [7:0] ADDR_EOI     = 8'h03;
  localparam logic [7:0] ADDR_VECTOR  = 8'h04;

  localparam int CTRL_GIE   = 0;
  localparam int CTRL_INSVC = 1;

  // Source index width; sources are limited to 8.
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder, purely combinational.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latching, masked, prioritised interrupt controller with a
// vectored req/ack handshake and an 8-bit register bus.
// Build option IRQ_CTRL_SYNC_EN: two-flop synchroniser on every irq_in bit.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int         N_IRQ         = 8,
  parameter logic [7:0] VECTOR_BASE   = 8'h10,
  parameter int         VECTOR_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [7:0]       din,
  input  logic [7:0]       address,
  input  logic             w_en,
  input  logic             r_en,
  output logic [7:0]       dout,
  output logic             irq_req,
  output logic [7:0]       irq_vector,
  input  logic             irq_ack
);

  logic [N_IRQ-1:0] w_src;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_enable;
  logic             r_gie;
  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_vec;
  logic             w_valid;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_vec;
  logic             w_in_svc;
  logic             w_take;
  logic             w_ack;
  logic             w_eoi;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_ack_clr;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_IRQ-1:0] r_sync1, r_sync2;

  // Two-flop synchroniser for sources not timed to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_in;
`endif

  // History is reset to 0 so a source already high at reset release counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= w_src;
  end

  assign w_edge    = w_src & ~r_prev;
  assign w_ack     = (r_state == ST_REQUEST) & irq_ack;
  assign w_eoi     = w_en & (address == ADDR_EOI);
  assign w_w1c     = (w_en && address == ADDR_PENDING) ? din[N_IRQ-1:0] : '0;
  assign w_ack_clr = w_ack ? (N_IRQ'(1) << r_idx) : '0;

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .i_req   (r_pending & r_enable),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_vec  = VECTOR_BASE + 8'(w_idx) * 8'(VECTOR_STRIDE);
  assign w_take = r_gie & w_valid;

  // Pending: clears (W1C or ack) are applied first so a same-cycle edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_w1c & ~w_ack_clr) | w_edge;
  end

  // ENABLE and GIE configuration writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= '0;
      r_gie    <= 1'b0;
    end else if (w_en) begin
      if (address == ADDR_ENABLE) r_enable <= din[N_IRQ-1:0];
      if (address == ADDR_CTRL)   r_gie    <= din[CTRL_GIE];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; ack takes precedence over a same-cycle GIE clear.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_take) w_state_nxt = ST_REQUEST;
      ST_REQUEST: if (irq_ack) w_state_nxt = ST_SERVICE;
                  else if (!r_gie) w_state_nxt = ST_IDLE;
      ST_SERVICE: if (w_eoi) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    irq_req  = (r_state == ST_REQUEST);
    w_in_svc = (r_state == ST_SERVICE);
  end

  // Capture the candidate when leaving IDLE; held unchanged through REQUEST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_vec <= 8'h00;
    end else if (r_state == ST_IDLE && w_take) begin
      r_idx <= w_idx;
      r_vec <= w_vec;
    end
  end

  assign irq_vector = r_vec;

  // Registered read port; holds its value when not reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'h00;
    end else if (r_en) begin
      case (address)
        ADDR_ENABLE:  dout <= 8'(r_enable);
        ADDR_PENDING: dout <= 8'(r_pending);
        ADDR_CTRL:    dout <= {6'b0, w_in_svc, r_gie};
        ADDR_VECTOR:  dout <= w_valid ? w_vec : 8'h00;
        default:      dout <= 8'h00;
      endcase
    end
  end

endmodule
